// File: rtl/coherence_bus_ctrl_n.sv
// Snooping MSI bus controller: round-robin grant, snoop, block transfer from RAM or owning cache.
// Optional `COH_STATS_EN adds saturating counters stat_c2c / stat_memrd.
module coherence_bus_ctrl_n #(
  parameter int NCPU     = 2,
  parameter int BLKWORDS = 2,
  parameter int SNPCYC   = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NCPU-1:0]      iREN,
  input  logic [NCPU-1:0]      dREN,
  input  logic [NCPU-1:0]      dWEN,
  input  logic [NCPU-1:0]      cctrans,
  input  logic [NCPU-1:0]      ccwrite,
  input  logic [NCPU*32-1:0]   iaddr,
  input  logic [NCPU*32-1:0]   daddr,
  input  logic [NCPU*32-1:0]   dstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic [NCPU-1:0]      iwait,
  output logic [NCPU-1:0]      dwait,
  output logic [NCPU*32-1:0]   iload,
  output logic [NCPU*32-1:0]   dload,
  output logic [NCPU-1:0]      ccwait,
  output logic [NCPU-1:0]      ccinv,
  output logic [NCPU*32-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore
`ifdef COH_STATS_EN
  ,
  output logic [15:0]          stat_c2c,
  output logic [15:0]          stat_memrd
`endif
);

  localparam int GW  = $clog2(NCPU);
  localparam int WCW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
  localparam int SCW = $clog2(SNPCYC + 1);

  typedef enum logic [2:0] {IDLE, SNOOP, LD, FWD, FLUSH, WB, IRD, INV} state_t;
  typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ramstate_t;

  state_t         state;
  logic [GW-1:0]  gnt, rr, owner, pick, own;
  logic [WCW-1:0] wcnt;
  logic [SCW-1:0] snp;
  logic           gap, rdx, found, own_found, access, last_word, done;
  logic [NCPU-1:0] others;
  int unsigned    idx;

  logic [31:0] iaddr_a [NCPU];
  logic [31:0] daddr_a [NCPU];
  logic [31:0] dstore_a [NCPU];
  logic [31:0] iload_a [NCPU];
  logic [31:0] dload_a [NCPU];
  logic [31:0] snp_a [NCPU];

  for (genvar g = 0; g < NCPU; g++) begin : g_lane
    assign iaddr_a[g]             = iaddr[g*32 +: 32];
    assign daddr_a[g]             = daddr[g*32 +: 32];
    assign dstore_a[g]            = dstore[g*32 +: 32];
    assign iload[g*32 +: 32]       = iload_a[g];
    assign dload[g*32 +: 32]       = dload_a[g];
    assign ccsnoopaddr[g*32 +: 32] = snp_a[g];
  end

  assign access    = (ramstate_t'(ramstate) == RS_ACCESS);
  assign last_word = (wcnt == WCW'(BLKWORDS - 1));
  assign others    = ~(NCPU'(1) << gnt);

  // Round-robin: first requester at or after rr, wrapping modulo NCPU.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NCPU; k++) begin
      idx = 32'(rr) + k;
      if (idx >= NCPU) idx = idx - NCPU;
      if (!found && (cctrans[GW'(idx)] || iREN[GW'(idx)])) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    own_found = 1'b0;
    own       = '0;
    for (int unsigned k = 0; k < NCPU; k++) begin
      if (!own_found && GW'(k) != gnt && cctrans[GW'(k)]) begin
        own_found = 1'b1;
        own       = GW'(k);
      end
    end
  end

  always_comb begin
    unique case (state)
      INV:         done = 1'b1;
      LD, IRD, WB: done = !gap && access && last_word;
      FWD:         done = !gap && rdx && last_word;
      FLUSH:       done = access && last_word;
      default:     done = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= '0;
      rr    <= '0;
      owner <= '0;
      wcnt  <= '0;
      snp   <= '0;
      gap   <= 1'b0;
      rdx   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (found) begin
          gnt  <= pick;
          rdx  <= ccwrite[pick];
          wcnt <= '0;
          snp  <= '0;
          gap  <= 1'b0;
          if (dREN[pick])      state <= SNOOP;
          else if (dWEN[pick]) state <= WB;
          else if (iREN[pick]) state <= IRD;
          else                 state <= INV;
        end
        SNOOP: if (snp == SCW'(SNPCYC - 1)) begin
          snp   <= '0;
          owner <= own;
          state <= own_found ? FWD : LD;
        end else begin
          snp <= snp + SCW'(1);
        end
        LD, IRD, WB: if (gap) begin
          gap <= 1'b0;
        end else if (access && !last_word) begin
          wcnt <= wcnt + WCW'(1);
          gap  <= 1'b1;
        end
        FWD: if (gap) begin
          gap <= 1'b0;
        end else if (!rdx) begin
          state <= FLUSH;
        end else if (!last_word) begin
          wcnt <= wcnt + WCW'(1);
          gap  <= 1'b1;
        end
        FLUSH: if (access && !last_word) begin
          wcnt  <= wcnt + WCW'(1);
          gap   <= 1'b1;
          state <= FWD;
        end
        default: ;
      endcase
      // Completion overrides the per-state updates above.
      if (done) begin
        state <= IDLE;
        wcnt  <= '0;
        rr    <= (gnt == GW'(NCPU - 1)) ? '0 : gnt + GW'(1);
      end
    end
  end

`ifdef COH_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_c2c   <= '0;
      stat_memrd <= '0;
    end else if (done) begin
      if (state == LD && stat_memrd != '1) stat_memrd <= stat_memrd + 16'd1;
      if ((state == FWD || state == FLUSH) && stat_c2c != '1) stat_c2c <= stat_c2c + 16'd1;
    end
  end
`endif

  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int unsigned k = 0; k < NCPU; k++) begin
      iload_a[k] = '0;
      dload_a[k] = '0;
      snp_a[k]   = '0;
    end
    unique case (state)
      SNOOP: begin
        ccwait = others;
        ccinv  = rdx ? others : '0;
        for (int unsigned k = 0; k < NCPU; k++) snp_a[k] = daddr_a[gnt];
      end
      LD: begin
        ccwait = others;
        if (!gap) begin
          ramREN  = 1'b1;
          ramaddr = daddr_a[gnt];
          if (access) begin
            dload_a[gnt] = ramload;
            dwait[gnt]   = 1'b0;
          end
        end
      end
      IRD: if (!gap) begin
        ramREN  = 1'b1;
        ramaddr = iaddr_a[gnt];
        if (access) begin
          iload_a[gnt] = ramload;
          iwait[gnt]   = 1'b0;
        end
      end
      WB: if (!gap) begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_a[gnt];
        ramstore = dstore_a[gnt];
        if (access) dwait[gnt] = 1'b0;
      end
      FWD: begin
        ccwait = others;
        if (!gap) begin
          dload_a[gnt] = dstore_a[owner];
          dwait[gnt]   = 1'b0;
          if (rdx) dwait[owner] = 1'b0;
        end
      end
      FLUSH: begin
        ccwait   = others;
        ramWEN   = 1'b1;
        ramaddr  = daddr_a[owner];
        ramstore = dstore_a[owner];
        if (access) dwait[owner] = 1'b0;
      end
      INV: begin
        ccinv = others;
        for (int unsigned k = 0; k < NCPU; k++) snp_a[k] = daddr_a[gnt];
      end
      default: ;
    endcase
  end

endmodule
